// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-ported register file: read, write, reserve and flush signals.
// The master modport drives requests; the slave modport is the register file side.
interface regfile_mp_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]      rd_busy_o;
  logic [NUM_WR-1:0]      wr_en_i;
  logic [NUM_WR*AW-1:0]   wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic                   rsv_en_i;
  logic [AW-1:0]          rsv_addr_i;
  logic                   flush_i;
  logic [NUM_REGS-1:0]    busy_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with hardwired-zero x0, write-first read bypass and a
// per-register busy scoreboard (reserve on issue, clear on writeback, flush clears all).
module regfile_mp #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     regs [1:NUM_REGS-1];
  logic [XLEN-1:0]     view [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [XLEN-1:0]     wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Per-register write decode; later ports overwrite earlier ones so the highest
  // index wins, and the same decode feeds both commit and bypass.
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) wr_val[r] = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en_i[w]) begin
        wr_hit[bus.wr_addr_i[w*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr_i[w*AW +: AW]] = bus.wr_data_i[w*XLEN +: XLEN];
      end
    end
    wr_hit[0] = 1'b0;
    wr_val[0] = '0;
  end

  always_comb begin
    view[0] = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) view[r] = regs[r];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
    end
  end

  // Reservation is applied after write clears so a new producer supersedes writeback.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush_i) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~wr_hit;
      if (bus.rsv_en_i && (bus.rsv_addr_i != '0)) busy_d[bus.rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy_o = busy_q;

  always_comb begin
    logic [AW-1:0] ra;
    ra            = '0;
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr_i[p*AW +: AW];
      bus.rd_data_o[p*XLEN +: XLEN] = wr_hit[ra] ? wr_val[ra] : view[ra];
      bus.rd_busy_o[p]              = busy_q[ra] & ~wr_hit[ra];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default and reduced geometry; expectations are queued
// as stimulus is driven and compared when the outputs are sampled.
module tb_regfile_mp;
  logic clk;
  logic rst_a;
  logic rst_b;

  regfile_mp_if #(.XLEN(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  regfile_mp_if #(.XLEN(32), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(3)) bus_b ();

  regfile_mp #(.XLEN(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) u_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave)
  );
  regfile_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(3)) u_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          dut_b;
    int unsigned kind;
    int unsigned idx;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam int unsigned K_DATA = 0;
  localparam int unsigned K_RBSY = 1;
  localparam int unsigned K_BUSY = 2;

  task automatic push_exp(string tag, bit b, int unsigned kind, int unsigned idx,
                          logic [63:0] val);
    exp_t e;
    e.tag = tag; e.dut_b = b; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] observe(exp_t e);
    logic [63:0] o;
    o = '0;
    if (!e.dut_b) begin
      case (e.kind)
        K_DATA:  o = bus_a.rd_data_o[e.idx*64 +: 64];
        K_RBSY:  o = 64'(bus_a.rd_busy_o[e.idx]);
        default: o = 64'(bus_a.busy_o);
      endcase
    end else begin
      case (e.kind)
        K_DATA:  o = 64'(bus_b.rd_data_o[e.idx*32 +: 32]);
        K_RBSY:  o = 64'(bus_b.rd_busy_o[e.idx]);
        default: o = 64'(bus_b.busy_o);
      endcase
    end
    return o;
  endfunction

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.rd_addr_i = '0; bus_a.wr_en_i = '0; bus_a.wr_addr_i = '0; bus_a.wr_data_i = '0;
    bus_a.rsv_en_i = 1'b0; bus_a.rsv_addr_i = '0; bus_a.flush_i = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.rd_addr_i = '0; bus_b.wr_en_i = '0; bus_b.wr_addr_i = '0; bus_b.wr_data_i = '0;
    bus_b.rsv_en_i = 1'b0; bus_b.rsv_addr_i = '0; bus_b.flush_i = 1'b0;
  endtask

  task automatic wr_a(int unsigned w, logic [4:0] a, logic [63:0] d);
    bus_a.wr_en_i[w] = 1'b1;
    bus_a.wr_addr_i[w*5 +: 5] = a;
    bus_a.wr_data_i[w*64 +: 64] = d;
  endtask

  task automatic rd_a(int unsigned p, logic [4:0] a);
    bus_a.rd_addr_i[p*5 +: 5] = a;
  endtask

  task automatic wr_b(int unsigned w, logic [3:0] a, logic [31:0] d);
    bus_b.wr_en_i[w] = 1'b1;
    bus_b.wr_addr_i[w*4 +: 4] = a;
    bus_b.wr_data_i[w*32 +: 32] = d;
  endtask

  task automatic rd_b(int unsigned p, logic [3:0] a);
    bus_b.rd_addr_i[p*4 +: 4] = a;
  endtask

  function automatic logic [63:0] pat(int unsigned r);
    return {32'(r) * 32'h9E37_79B9, ~32'(r)};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_a();
    idle_b();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    push_exp("rst_busy_a", 0, K_BUSY, 0, 64'h0);
    push_exp("rst_busy_b", 1, K_BUSY, 0, 64'h0);
    drain();
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // Reset contents on every read port
    for (int unsigned r = 1; r < 32; r++) begin
      rd_a(0, 5'(r)); rd_a(1, 5'(32 - r));
      #1;
      push_exp("rst_rd0_a", 0, K_DATA, 0, 64'h0);
      push_exp("rst_rd1_a", 0, K_DATA, 1, 64'h0);
      drain();
    end
    for (int unsigned r = 0; r < 16; r++) begin
      for (int unsigned p = 0; p < 4; p++) rd_b(p, 4'(r + p));
      #1;
      for (int unsigned p = 0; p < 4; p++) push_exp("rst_rd_b", 1, K_DATA, p, 64'h0);
      drain();
    end
    push_exp("rst_busy_a2", 0, K_BUSY, 0, 64'h0);
    drain();
    tick();

    // Bypass then stored value
    idle_a();
    wr_a(0, 5'd5, 64'hDEAD_BEEF_0000_0001); rd_a(1, 5'd5); rd_a(0, 5'd6);
    #2;
    push_exp("byp_rd1", 0, K_DATA, 1, 64'hDEAD_BEEF_0000_0001);
    push_exp("byp_other", 0, K_DATA, 0, 64'h0);
    push_exp("byp_rbsy", 0, K_RBSY, 1, 64'h0);
    drain();
    tick();
    idle_a(); rd_a(1, 5'd5);
    #2;
    push_exp("stored_x5", 0, K_DATA, 1, 64'hDEAD_BEEF_0000_0001);
    push_exp("nonbusy_wr", 0, K_BUSY, 0, 64'h0);
    drain();

    // Write-write collision and x0
    idle_a();
    wr_a(0, 5'd7, 64'h1); wr_a(1, 5'd7, 64'h2); rd_a(0, 5'd7);
    #2;
    push_exp("coll_byp", 0, K_DATA, 0, 64'h2);
    drain();
    tick();
    idle_a(); rd_a(0, 5'd7);
    #2;
    push_exp("coll_stored", 0, K_DATA, 0, 64'h2);
    drain();
    idle_a();
    wr_a(0, 5'd0, 64'hFFFF); rd_a(0, 5'd0); rd_a(1, 5'd0);
    #2;
    push_exp("x0_byp", 0, K_DATA, 0, 64'h0);
    drain();
    tick();
    idle_a();
    #2;
    push_exp("x0_stored", 0, K_DATA, 1, 64'h0);
    drain();

    // Reserve, writeback clear, reserve-beats-write
    idle_a(); bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd9;
    tick();
    idle_a(); rd_a(0, 5'd9);
    #1;
    push_exp("rsv_busy9", 0, K_BUSY, 0, 64'h1 << 9);
    push_exp("rsv_rbsy", 0, K_RBSY, 0, 64'h1);
    drain();
    wr_a(0, 5'd9, 64'h99);
    #1;
    push_exp("wb_rbsy", 0, K_RBSY, 0, 64'h0);
    push_exp("wb_byp", 0, K_DATA, 0, 64'h99);
    drain();
    tick();
    idle_a(); rd_a(0, 5'd9);
    #1;
    push_exp("wb_cleared", 0, K_BUSY, 0, 64'h0);
    push_exp("wb_stored", 0, K_DATA, 0, 64'h99);
    drain();
    bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd9; wr_a(1, 5'd9, 64'h77);
    tick();
    idle_a(); rd_a(1, 5'd9);
    #1;
    push_exp("rsv_wins", 0, K_BUSY, 0, 64'h1 << 9);
    push_exp("rsv_wins_data", 0, K_DATA, 1, 64'h77);
    push_exp("rsv_wins_rbsy", 0, K_RBSY, 1, 64'h1);
    drain();

    // Multiple reservations then flush with a reserve and a write
    idle_a(); bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd3;
    tick();
    bus_a.rsv_addr_i = 5'd4;
    tick();
    bus_a.rsv_addr_i = 5'd6;
    tick();
    idle_a();
    #1;
    push_exp("multi_rsv", 0, K_BUSY, 0, (64'h1 << 3) | (64'h1 << 4) | (64'h1 << 6) | (64'h1 << 9));
    drain();
    bus_a.flush_i = 1'b1; bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd8;
    wr_a(0, 5'd3, 64'h55);
    tick();
    idle_a(); rd_a(0, 5'd3); rd_a(1, 5'd8);
    #1;
    push_exp("flush_busy", 0, K_BUSY, 0, 64'h0);
    push_exp("flush_wr", 0, K_DATA, 0, 64'h55);
    push_exp("flush_rbsy", 0, K_RBSY, 1, 64'h0);
    drain();

    // Fill every register through alternating ports and read back
    for (int unsigned r = 1; r < 32; r++) begin
      idle_a(); wr_a(r % 2, 5'(r), pat(r));
      tick();
    end
    idle_a();
    for (int unsigned r = 1; r < 32; r++) begin
      rd_a(0, 5'(r)); rd_a(1, 5'(32 - r));
      #1;
      push_exp("walk_rd0", 0, K_DATA, 0, pat(r));
      push_exp("walk_rd1", 0, K_DATA, 1, pat(32 - r));
      drain();
    end
    push_exp("walk_busy", 0, K_BUSY, 0, 64'h0);
    drain();
    tick();

    // Asynchronous reset between edges
    idle_a(); wr_a(0, 5'd10, 64'hA); bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd11;
    tick();
    idle_a(); rd_a(0, 5'd10); rd_a(1, 5'd11);
    #1;
    push_exp("pre_rst_x10", 0, K_DATA, 0, 64'hA);
    push_exp("pre_rst_busy", 0, K_BUSY, 0, 64'h1 << 11);
    drain();
    #1;
    rst_a = 1'b0;
    #1;
    push_exp("arst_x10", 0, K_DATA, 0, 64'h0);
    push_exp("arst_x11", 0, K_DATA, 1, 64'h0);
    push_exp("arst_busy", 0, K_BUSY, 0, 64'h0);
    push_exp("arst_rbsy", 0, K_RBSY, 1, 64'h0);
    drain();
    wr_a(0, 5'd10, 64'h3); bus_a.rsv_en_i = 1'b1; bus_a.rsv_addr_i = 5'd12;
    #1;
    push_exp("arst_byp", 0, K_DATA, 0, 64'h3);
    drain();
    tick();
    idle_a(); rd_a(0, 5'd10);
    #1;
    push_exp("arst_nocommit", 0, K_DATA, 0, 64'h0);
    push_exp("arst_norsv", 0, K_BUSY, 0, 64'h0);
    drain();
    rst_a = 1'b1;
    tick();
    rd_a(1, 5'd5);
    #1;
    push_exp("post_rst_x5", 0, K_DATA, 1, 64'h0);
    drain();

    // Reduced geometry: three-way collision and priority with a gap
    idle_b();
    wr_b(0, 4'd2, 32'h1); wr_b(1, 4'd2, 32'h2); wr_b(2, 4'd2, 32'h3);
    rd_b(3, 4'd2); rd_b(0, 4'd1);
    #1;
    push_exp("b_coll3_byp", 1, K_DATA, 3, 64'h3);
    push_exp("b_other", 1, K_DATA, 0, 64'h0);
    drain();
    tick();
    idle_b();
    wr_b(0, 4'd5, 32'h5); wr_b(1, 4'd6, 32'h66); wr_b(2, 4'd5, 32'h6);
    rd_b(0, 4'd2); rd_b(1, 4'd5); rd_b(2, 4'd6);
    #1;
    push_exp("b_coll3_stored", 1, K_DATA, 0, 64'h3);
    push_exp("b_gap_byp", 1, K_DATA, 1, 64'h6);
    push_exp("b_w1_byp", 1, K_DATA, 2, 64'h66);
    drain();
    tick();
    idle_b(); rd_b(3, 4'd5); rd_b(2, 4'd6);
    #1;
    push_exp("b_gap_stored", 1, K_DATA, 3, 64'h6);
    push_exp("b_w1_stored", 1, K_DATA, 2, 64'h66);
    drain();

    // Reduced geometry: reserve then asynchronous reset
    idle_b(); wr_b(2, 4'd10, 32'hA); bus_b.rsv_en_i = 1'b1; bus_b.rsv_addr_i = 4'd11;
    tick();
    idle_b(); rd_b(0, 4'd10); rd_b(3, 4'd11);
    #1;
    push_exp("b_pre_x10", 1, K_DATA, 0, 64'hA);
    push_exp("b_pre_busy", 1, K_BUSY, 0, 64'h1 << 11);
    push_exp("b_pre_rbsy", 1, K_RBSY, 3, 64'h1);
    drain();
    #1;
    rst_b = 1'b0;
    #1;
    push_exp("b_arst_x10", 1, K_DATA, 0, 64'h0);
    push_exp("b_arst_busy", 1, K_BUSY, 0, 64'h0);
    push_exp("b_arst_rbsy", 1, K_RBSY, 3, 64'h0);
    drain();
    tick();
    rst_b = 1'b1;
    tick();
    rd_b(1, 4'd2);
    #1;
    push_exp("b_post_x2", 1, K_DATA, 1, 64'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- XLEN, 64, data width.
- NUM_REGS, 32, architectural registers (power of two, min 2).
- NUM_RD, 2, read ports.
- NUM_WR, 2, write ports.
- AW = $clog2(NUM_REGS), derived address width (localparam).

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.

REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-low reset.
- rd_addr_i, in, NUM_RD*AW, read addresses; port p = slice p.
- rd_data_o, out, NUM_RD*XLEN, read data per port.
- rd_busy_o, out, NUM_RD, pending-write flag per read port.
- wr_en_i, in, NUM_WR, write enables.
- wr_addr_i, in, NUM_WR*AW, write addresses.
- wr_data_i, in, NUM_WR*XLEN, write data.
- rsv_en_i, in, 1, reserve request (instruction issue).
- rsv_addr_i, in, AW, destination register to mark busy.
- flush_i, in, 1, clear all busy bits (pipeline flush).
- busy_o, out, NUM_REGS, registered scoreboard vector; bit r = register r.

Function
REQ-004 Storage SHALL be NUM_REGS-1 XLEN-bit flops for registers 1..NUM_REGS-1; register 0 SHALL have no storage.
- Reads of address 0 SHALL return 0.
- Writes to address 0 SHALL be ignored.
- busy_o[0] SHALL always be 0.

REQ-005 Writes SHALL commit at the rising clk edge for every port with wr_en_i=1 and a nonzero address.

REQ-006 Write-write collision: when two or more enabled write ports target the same address in one cycle, the highest-indexed port's data SHALL commit.

REQ-007 Reads SHALL be combinational, zero-latency, write-first bypassed.
- If any enabled write port targets rd_addr_i[p] (nonzero) in the same cycle, rd_data_o[p] SHALL equal that write's data.
- The REQ-006 priority SHALL apply to the bypass.
- Otherwise rd_data_o[p] SHALL equal the stored value.

REQ-008 Scoreboard busy bits SHALL update at each rising clk edge by this priority:
- flush_i=1: all bits cleared, rsv_en_i and writes ignored for busy purposes (data writes still commit).
- Else, reservation: busy[rsv_addr_i] set when rsv_en_i=1 and rsv_addr_i≠0. Reserve wins over a same-cycle write to the same address (a new producer supersedes the old).
- Else, write: busy[a] cleared for each enabled write address a.

REQ-009 Read-port busy flag: rd_busy_o[p] = busy[rd_addr_i[p]] AND NOT (any enabled write to rd_addr_i[p] this cycle). It SHALL be 0 for address 0.

REQ-010 A write to a non-busy register SHALL commit data and leave busy at 0.

REQ-011 Out-of-range addresses SHALL be impossible by construction: AW bits cover exactly NUM_REGS.

REQ-012 All read paths and rd_busy_o SHALL be purely combinational from inputs and state. There SHALL be no combinational path from rd_* to wr_* or rsv_*.

Reset
REQ-013 While reset=0, asynchronously:
- All registers SHALL be 0 and all busy bits SHALL be 0.
- rd_data_o SHALL show 0 for all ports unless a same-cycle write bypass is active; writes and reservations SHALL NOT commit.

REQ-014 Reset asserted mid-operation SHALL discard all pending writes and reservations with no partial update. Deassertion SHALL be synchronised externally; the first commit occurs at the first rising edge after reset=1.

Verification
REQ-015 Reset then read x1..x31 on all ports -> all rd_data_o=0, busy_o=0.

REQ-016 Write x5=64'hDEAD_BEEF_0000_0001 on port0; same cycle read x5 on port1 -> rd_data_o[1] shows bypass value. Next cycle, with no write, the read returns the stored value.

REQ-017 Same-cycle port0 x7=64'h1 and port1 x7=64'h2 -> bypass and stored value = 64'h2. Write x0=64'hFFFF via port0 -> x0 reads 0.

REQ-018 Reserve x9; next cycle busy_o[9]=1 and rd_busy_o=1 for a read of x9. A write to x9 in that cycle gives rd_busy_o=0, bypass data; after the edge busy_o[9]=0. A same-cycle reserve and write of x9 leaves busy_o[9]=1.

REQ-019 Reserve x3, x4, x6 on consecutive cycles, then flush_i with rsv x8 -> busy_o all 0 after the edge. A write of x3=64'h55 in the flush cycle still commits 64'h55.

REQ-020 Write x10=64'hA, reserve x11, pulse reset low asynchronously between edges -> x10 reads 0 and busy_o=0 immediately. Repeat at NUM_RD=4, NUM_WR=3, NUM_REGS=16, XLEN=32.
